// File: rtl/musa_ctrl_pkg.sv
// Shared MUSA control encodings.
// Contents:
//   br_sel_e          : branch select encodings driven by the control unit
//   FLAG_Z..FLAG_V    : bit positions of the ALU flags within the 4-bit flag bus
package musa_ctrl_pkg;

  typedef enum logic [1:0] {
    BR_SEQ  = 2'b00,
    BR_HALT = 2'b01,
    BR_JUMP = 2'b10,
    BR_RSVD = 2'b11
  } br_sel_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: register-array LIFO of DEPTH x W.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears occupancy only)
//   push, pop  : qualified strobes; the parent guarantees no push when full,
//                no pop when empty, and never both together
//   wdata      : value stored on push
//   rdata      : current top-of-stack entry (meaningless when empty)
//   sp         : occupancy 0..DEPTH
//   full/empty : occupancy status
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     full,
  output logic                     empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int SP_W = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] top_idx;

  // Low bits of sp minus one wrap correctly even at sp==DEPTH.
  assign top_idx = sp[AW-1:0] - AW'(1);
  assign rdata   = mem[top_idx];
  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);

  // Entries need no reset; only occupancy defines validity.
  always_ff @(posedge clk) begin
    if (push) mem[sp[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sp <= '0;
    else if (push) sp <= sp + SP_W'(1);
    else if (pop)  sp <= sp - SP_W'(1);
  end

endmodule

// File: rtl/pc_call_stack_unit.sv
// Program-counter stage with hardware return-address stack.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   write_pc            : per-instruction commit strobe
//   branch              : 00 seq, 01 halt, 10 jump, 11 treated as seq
//   brfl_control        : makes a jump conditional on (flags & cond_mask) != 0
//   flags, cond_mask    : ALU flags and instruction flag mask
//   jr_sel              : jump target select (1 reg_target, 0 imm_target)
//   imm_target          : immediate jump / call target
//   reg_target          : register jump target
//   push, pop, add_pc   : call, return, return-past-call adjust
//   pc                  : registered current PC
//   halted              : sticky halt (halt instruction or any fault)
//   stack_overflow      : sticky, call with full stack
//   stack_underflow     : sticky, return with empty stack
//   illegal_ctrl        : sticky, push and pop in the same commit
//   sp                  : stack occupancy 0..DEPTH
module pc_call_stack_unit
  import musa_ctrl_pkg::*;
#(
  parameter int                PC_W     = 32,
  parameter int                PC_INC   = 1,
  parameter int                DEPTH    = 8,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_pc,
  input  logic [1:0]               branch,
  input  logic                     brfl_control,
  input  logic [3:0]               flags,
  input  logic [3:0]               cond_mask,
  input  logic                     jr_sel,
  input  logic [PC_W-1:0]          imm_target,
  input  logic [PC_W-1:0]          reg_target,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     add_pc,
  output logic [PC_W-1:0]          pc,
  output logic                     halted,
  output logic                     stack_overflow,
  output logic                     stack_underflow,
  output logic                     illegal_ctrl,
  output logic [$clog2(DEPTH):0]   sp
);

  localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

  logic            commit;
  logic            stk_push, stk_pop, stk_full, stk_empty;
  logic [PC_W-1:0] stk_top;
  logic [PC_W-1:0] pc_nxt;
  logic            halt_nxt, ovf_nxt, unf_nxt, ill_nxt;
  logic            jump_taken;

  assign commit     = write_pc & ~halted;
  assign jump_taken = ~brfl_control | (|(flags & cond_mask));

  ras_stack #(.DEPTH(DEPTH), .W(PC_W)) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stk_push),
    .pop   (stk_pop),
    .wdata (pc),
    .rdata (stk_top),
    .sp    (sp),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    pc_nxt   = pc;
    halt_nxt = halted;
    ovf_nxt  = stack_overflow;
    unf_nxt  = stack_underflow;
    ill_nxt  = illegal_ctrl;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    if (commit) begin
      if (push && pop) begin
        ill_nxt  = 1'b1;
        halt_nxt = 1'b1;
      end else if (push) begin
        if (stk_full) begin
          ovf_nxt  = 1'b1;
          halt_nxt = 1'b1;
        end else begin
          stk_push = 1'b1;
          pc_nxt   = imm_target;
        end
      end else if (pop) begin
        if (stk_empty) begin
          unf_nxt  = 1'b1;
          halt_nxt = 1'b1;
        end else begin
          stk_pop = 1'b1;
          pc_nxt  = stk_top + (add_pc ? INC : '0);
        end
      end else begin
        case (branch)
          BR_HALT: halt_nxt = 1'b1;
          BR_JUMP: pc_nxt   = jump_taken ? (jr_sel ? reg_target : imm_target)
                                         : pc + INC;
          default: pc_nxt   = pc + INC;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc              <= RESET_PC;
      halted          <= 1'b0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
      illegal_ctrl    <= 1'b0;
    end else begin
      pc              <= pc_nxt;
      halted          <= halt_nxt;
      stack_overflow  <= ovf_nxt;
      stack_underflow <= unf_nxt;
      illegal_ctrl    <= ill_nxt;
    end
  end

endmodule

// File: tb/tb_pc_call_stack_unit.sv
module tb_pc_call_stack_unit;
  import musa_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_pc;
  logic [1:0]  branch;
  logic        brfl_control;
  logic [3:0]  flags, cond_mask;
  logic        jr_sel;
  logic [31:0] imm_target, reg_target;
  logic        push, pop, add_pc;
  logic [31:0] pc;
  logic        halted, stack_overflow, stack_underflow, illegal_ctrl;
  logic [3:0]  sp;

  pc_call_stack_unit dut (
    .clk(clk), .rst_n(rst_n), .write_pc(write_pc), .branch(branch),
    .brfl_control(brfl_control), .flags(flags), .cond_mask(cond_mask),
    .jr_sel(jr_sel), .imm_target(imm_target), .reg_target(reg_target),
    .push(push), .pop(pop), .add_pc(add_pc), .pc(pc), .halted(halted),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow),
    .illegal_ctrl(illegal_ctrl), .sp(sp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  br;
    logic        brfl;
    logic [3:0]  flg;
    logic [3:0]  msk;
    logic        jr;
    logic [31:0] imm;
    logic [31:0] rt;
    logic        psh;
    logic        pp;
    logic        addp;
    logic [31:0] e_pc;
    logic [3:0]  e_sp;
    logic        e_halt;
    logic        e_ovf;
    logic        e_unf;
    logic        e_ill;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  sp;
    logic        halt;
    logic        ovf;
    logic        unf;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[20];

  function automatic vec_t mk(logic [1:0] br, logic brfl, logic [3:0] flg,
                              logic [3:0] msk, logic jr, logic [31:0] imm,
                              logic [31:0] rt, logic psh, logic pp, logic addp,
                              logic [31:0] e_pc, logic [3:0] e_sp, logic e_halt,
                              logic e_ovf, logic e_unf, logic e_ill);
    vec_t v;
    v.br = br; v.brfl = brfl; v.flg = flg; v.msk = msk; v.jr = jr;
    v.imm = imm; v.rt = rt; v.psh = psh; v.pp = pp; v.addp = addp;
    v.e_pc = e_pc; v.e_sp = e_sp; v.e_halt = e_halt;
    v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_ill = e_ill;
    return v;
  endfunction

  function automatic exp_t ex(logic [31:0] p, logic [3:0] s, logic h,
                              logic o, logic u, logic i);
    exp_t e;
    e.pc = p; e.sp = s; e.halt = h; e.ovf = o; e.unf = u; e.ill = i;
    return e;
  endfunction

  task automatic idle_inputs();
    write_pc = 0; branch = BR_SEQ; brfl_control = 0; flags = 0; cond_mask = 0;
    jr_sel = 0; imm_target = 0; reg_target = 0; push = 0; pop = 0; add_pc = 0;
  endtask

  // Pops the oldest expectation and checks all outputs against it.
  task automatic check_out(string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (pc !== e.pc || sp !== e.sp || halted !== e.halt ||
        stack_overflow !== e.ovf || stack_underflow !== e.unf ||
        illegal_ctrl !== e.ill) begin
      n_bad++;
      $display("FAIL %s: got pc=%h sp=%0d h=%b o=%b u=%b i=%b, want pc=%h sp=%0d h=%b o=%b u=%b i=%b",
               name, pc, sp, halted, stack_overflow, stack_underflow, illegal_ctrl,
               e.pc, e.sp, e.halt, e.ovf, e.unf, e.ill);
    end
  endtask

  // Called just after a negedge: drive one commit, check after the edge,
  // then check the outputs hold through an idle cycle.
  task automatic apply(vec_t v, string name);
    branch = v.br; brfl_control = v.brfl; flags = v.flg; cond_mask = v.msk;
    jr_sel = v.jr; imm_target = v.imm; reg_target = v.rt;
    push = v.psh; pop = v.pp; add_pc = v.addp; write_pc = 1;
    exp_q.push_back(ex(v.e_pc, v.e_sp, v.e_halt, v.e_ovf, v.e_unf, v.e_ill));
    exp_q.push_back(ex(v.e_pc, v.e_sp, v.e_halt, v.e_ovf, v.e_unf, v.e_ill));
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_out(name);
    @(negedge clk);
    check_out({name, "_hold"});
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #7;
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1;
    idle_inputs();
    @(negedge clk);
    do_reset();
    exp_q.push_back(ex(32'h0, 4'd0, 0, 0, 0, 0));
    check_out("reset");

    //            br       brfl flg   msk   jr imm          rt           ps pp ad  e_pc          sp h o u i
    tbl[0]  = mk(BR_SEQ,  0, 4'h0, 4'h0, 0, 32'h0,       32'h0,       0, 0, 0, 32'h1,        0, 0, 0, 0, 0);
    tbl[1]  = mk(BR_SEQ,  0, 4'h0, 4'h0, 0, 32'h0,       32'h0,       0, 0, 0, 32'h2,        0, 0, 0, 0, 0);
    tbl[2]  = mk(BR_SEQ,  0, 4'h0, 4'h0, 0, 32'h0,       32'h0,       0, 0, 0, 32'h3,        0, 0, 0, 0, 0);
    tbl[3]  = mk(BR_RSVD, 0, 4'h0, 4'h0, 0, 32'h55,      32'h66,      0, 0, 0, 32'h4,        0, 0, 0, 0, 0);
    tbl[4]  = mk(BR_SEQ,  0, 4'h0, 4'h0, 0, 32'h0,       32'h0,       0, 0, 0, 32'h5,        0, 0, 0, 0, 0);
    tbl[5]  = mk(BR_JUMP, 1, 4'h0, 4'h1, 0, 32'h40,      32'h0,       0, 0, 0, 32'h6,        0, 0, 0, 0, 0);
    tbl[6]  = mk(BR_JUMP, 1, 4'h1, 4'h1, 0, 32'h40,      32'h0,       0, 0, 0, 32'h40,       0, 0, 0, 0, 0);
    tbl[7]  = mk(BR_JUMP, 0, 4'h0, 4'h0, 1, 32'h40,      32'h80,      0, 0, 0, 32'h80,       0, 0, 0, 0, 0);
    tbl[8]  = mk(BR_JUMP, 1, 4'h9, 4'h6, 0, 32'h99,      32'h0,       0, 0, 0, 32'h81,       0, 0, 0, 0, 0);
    tbl[9]  = mk(BR_JUMP, 0, 4'h0, 4'h0, 0, 32'h10,      32'h0,       0, 0, 0, 32'h10,       0, 0, 0, 0, 0);
    tbl[10] = mk(BR_SEQ,  0, 4'h0, 4'h0, 0, 32'h100,     32'h0,       1, 0, 0, 32'h100,      1, 0, 0, 0, 0);
    tbl[11] = mk(BR_SEQ,  0, 4'h0, 4'h0, 0, 32'h0,       32'h0,       0, 1, 1, 32'h11,       0, 0, 0, 0, 0);
    tbl[12] = mk(BR_SEQ,  0, 4'h0, 4'h0, 0, 32'h200,     32'h0,       1, 0, 0, 32'h200,      1, 0, 0, 0, 0);
    tbl[13] = mk(BR_HALT, 0, 4'h0, 4'h0, 0, 32'h300,     32'h0,       1, 0, 0, 32'h300,      2, 0, 0, 0, 0);
    tbl[14] = mk(BR_JUMP, 0, 4'h0, 4'h0, 0, 32'h777,     32'h0,       0, 1, 0, 32'h200,      1, 0, 0, 0, 0);
    tbl[15] = mk(BR_SEQ,  0, 4'h0, 4'h0, 0, 32'h0,       32'h0,       0, 1, 1, 32'h12,       0, 0, 0, 0, 0);
    tbl[16] = mk(BR_JUMP, 0, 4'h0, 4'h0, 1, 32'h0,       32'hFFFFFFFF,0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    tbl[17] = mk(BR_SEQ,  0, 4'h0, 4'h0, 0, 32'h0,       32'h0,       0, 0, 0, 32'h0,        0, 0, 0, 0, 0);
    tbl[18] = mk(BR_HALT, 0, 4'h0, 4'h0, 0, 32'h0,       32'h0,       0, 0, 0, 32'h0,        0, 1, 0, 0, 0);
    tbl[19] = mk(BR_JUMP, 0, 4'h0, 4'h0, 0, 32'h123,     32'h0,       0, 0, 0, 32'h0,        0, 1, 0, 0, 0);

    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset asserted between edges takes effect at once.
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    exp_q.push_back(ex(32'h0, 4'd0, 0, 0, 0, 0));
    check_out("async_reset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Fill the stack, then overflow.
    for (int i = 0; i < 8; i++)
      apply(mk(BR_SEQ, 0, 0, 0, 0, 32'h1000 + 32'(i), 0, 1, 0, 0,
               32'h1000 + 32'(i), 4'(i + 1), 0, 0, 0, 0),
            $sformatf("push%0d", i));
    apply(mk(BR_SEQ, 0, 0, 0, 0, 32'h2000, 0, 1, 0, 0, 32'h1007, 4'd8, 1, 1, 0, 0), "overflow");
    apply(mk(BR_SEQ, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 32'h1007, 4'd8, 1, 1, 0, 0), "ovf_ignored");

    // Full stack unwinds in LIFO order (each entry is the caller's pc).
    do_reset();
    for (int i = 0; i < 8; i++)
      apply(mk(BR_SEQ, 0, 0, 0, 0, 32'h3000 + 32'(i), 0, 1, 0, 0,
               32'h3000 + 32'(i), 4'(i + 1), 0, 0, 0, 0),
            $sformatf("fill%0d", i));
    apply(mk(BR_SEQ, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h3006, 4'd7, 0, 0, 0, 0), "unwind7");
    apply(mk(BR_SEQ, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h3006, 4'd6, 0, 0, 0, 0), "unwind6");

    // Underflow from empty.
    do_reset();
    apply(mk(BR_SEQ, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 4'd0, 1, 0, 1, 0), "underflow");

    // Illegal push+pop.
    do_reset();
    apply(mk(BR_SEQ, 0, 0, 0, 0, 32'h50, 0, 1, 0, 0, 32'h50, 4'd1, 0, 0, 0, 0), "ill_setup");
    apply(mk(BR_JUMP, 0, 0, 0, 0, 32'h60, 0, 1, 1, 1, 32'h50, 4'd1, 1, 0, 0, 1), "illegal");
    apply(mk(BR_SEQ, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h50, 4'd1, 1, 0, 0, 1), "ill_ignored");

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL leftover: got %0d queued, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
